// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the boot loader.
// master drives the image stream; slave is the loader itself.
interface imem_boot_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
);
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic              LOAD_REQ;
  logic [ADDR_W-1:0] MEM_A;
  logic [WIDTH-1:0]  MEM_D;
  logic              MEM_CEN;
  logic              MEM_WEN;
  logic              CORE_RST;
  logic              DONE;
  logic              ERROR;

  modport master (
    output IN_DATA, IN_VALID, LOAD_REQ,
    input  IN_READY, MEM_A, MEM_D, MEM_CEN, MEM_WEN, CORE_RST, DONE, ERROR
  );

  modport slave (
    input  IN_DATA, IN_VALID, LOAD_REQ,
    output IN_READY, MEM_A, MEM_D, MEM_CEN, MEM_WEN, CORE_RST, DONE, ERROR
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory, then releases CORE_RST.
// Word write issues one cycle after its 4th byte; IN_READY never stalls during a load.
module imem_boot_loader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [WIDTH-9:0]  word_q, word_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [WIDTH-1:0]  mem_d_q, mem_d_d;
  logic              mem_cen_q, mem_cen_d;
  logic              mem_wen_q, mem_wen_d;
  logic              in_ready_q, in_ready_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   word_idx_inc;

  assign accept       = bus.IN_VALID && in_ready_q;
  assign n_words      = {bus.IN_DATA, len_lo_q};
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    word_d     = word_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    mem_cen_d  = 1'b1;
    mem_wen_d  = 1'b1;

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_lo_d = bus.IN_DATA;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          if (n_words == 16'd0 || n_words > 16'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            len_d      = n_words[ADDR_W:0];
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ bus.IN_DATA;
          byte_idx_d = byte_idx_q + 1'b1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.IN_DATA;
            2'd1: word_d[15:8]  = bus.IN_DATA;
            2'd2: word_d[23:16] = bus.IN_DATA;
            default: begin
              // The 4th byte goes straight to the write register; no extra assembly cycle.
              mem_a_d    = word_idx_q[ADDR_W-1:0];
              mem_d_d    = {bus.IN_DATA, word_q};
              mem_cen_d  = 1'b0;
              mem_wen_d  = 1'b0;
              word_idx_d = word_idx_inc;
              if (word_idx_inc == len_q) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.IN_DATA == csum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN, S_ERR: begin
        if (bus.LOAD_REQ) begin
          state_d    = S_LEN0;
          len_lo_d   = '0;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          word_d     = '0;
        end
      end
      default: state_d = S_LEN0;
    endcase

    // Status outputs are registered copies of the next state so they line up with it.
    in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
    core_rst_d = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      mem_cen_q  <= 1'b1;
      mem_wen_q  <= 1'b1;
      in_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      mem_cen_q  <= mem_cen_d;
      mem_wen_q  <= mem_wen_d;
      in_ready_q <= in_ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.IN_READY = in_ready_q;
  assign bus.MEM_A    = mem_a_q;
  assign bus.MEM_D    = mem_d_q;
  assign bus.MEM_CEN  = mem_cen_q;
  assign bus.MEM_WEN  = mem_wen_q;
  assign bus.CORE_RST = core_rst_q;
  assign bus.DONE     = done_q;
  assign bus.ERROR    = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: cycle-exact vector table for a small load, then directed
// sequences for bad checksum, bad length, stalled stream, mid-load reset and a full 2048-word image.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   stuck    = 1'b0;

  imem_boot_loader_if #(.WIDTH(32), .ADDR_W(11)) bus ();

  imem_boot_loader #(.WIDTH(32), .ADDR_W(11), .DEPTH(2048)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] exp_w [0:2047];

  // Write log: every cycle the memory port is enabled for a write.
  always @(negedge clk) begin
    if (bus.MEM_CEN == 1'b0 && bus.MEM_WEN == 1'b0) begin
      wr_t w;
      w.a = bus.MEM_A;
      w.d = bus.MEM_D;
      wr_q.push_back(w);
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        lr;
    logic        rdy;
    logic        cen;
    logic [10:0] a;
    logic [31:0] md;
    logic        crst;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    bit acc = 1'b0;
    int n   = 0;
    if (stuck) return;
    while (!acc) begin
      @(negedge clk);
      bus.IN_DATA  = b;
      bus.IN_VALID = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = bus.IN_VALID && bus.IN_READY;
      @(posedge clk);
      n++;
      if (!acc && n > 200) begin
        checks++;
        failures++;
        stuck = 1'b1;
        $display("FAIL byte_accept_timeout: byte %0h not accepted after %0d cycles", b, n);
        return;
      end
    end
  endtask

  task automatic send_payload(input int nw, input bit toggle, output logic [7:0] cs);
    logic [7:0] x;
    cs = 8'h00;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 4; b++) begin
        x  = exp_w[w][8*b +: 8];
        cs = cs ^ x;
        send_byte(x, toggle);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    #1;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.LOAD_REQ = 1'b1;
    @(negedge clk);
    bus.LOAD_REQ = 1'b0;
    #1;
  endtask

  task automatic check_writes(input string name, input int nw);
    int bad = 0;
    chk({name, "_count"}, wr_q.size(), nw);
    for (int i = 0; i < wr_q.size() && i < nw; i++) begin
      if (wr_q[i].a != 11'(i) || wr_q[i].d != exp_w[i]) bad++;
    end
    chk({name, "_order_data_bad"}, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;

    //              v     d      lr    rdy   cen   a       md            crst  done  err
    vecs[0]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 11'd0, 32'h00500013, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h93, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00500013, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00500013, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00500013, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 11'd0, 32'h00500013, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 11'd1, 32'h00100093, 1'b1, 1'b0, 1'b0};
    // 0x93 ^ 0x13 ^ 0x50 ^ 0x10 = 0xC0
    vecs[12] = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 11'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 11'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 11'd1, 32'h00100093, 1'b1, 1'b0, 1'b0};

    rst          = 1'b1;
    bus.IN_DATA  = 8'h00;
    bus.IN_VALID = 1'b0;
    bus.LOAD_REQ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",    bus.IN_READY, 1'b0);
    chk("rst_cen",      bus.MEM_CEN,  1'b1);
    chk("rst_wen",      bus.MEM_WEN,  1'b1);
    chk("rst_a",        bus.MEM_A,    11'd0);
    chk("rst_d",        bus.MEM_D,    32'd0);
    chk("rst_core_rst", bus.CORE_RST, 1'b1);
    chk("rst_done",     bus.DONE,     1'b0);
    chk("rst_error",    bus.ERROR,    1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_cycle1_ready", bus.IN_READY, 1'b0);
    @(posedge clk);
    #1;
    chk("rel_cycle2_ready", bus.IN_READY, 1'b1);

    // Cycle-exact good load of a 2-word image.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.IN_VALID = vecs[i].v;
      bus.IN_DATA  = vecs[i].d;
      bus.LOAD_REQ = vecs[i].lr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ready", i),    bus.IN_READY, vecs[i].rdy);
      chk($sformatf("vec%0d_cen", i),      bus.MEM_CEN,  vecs[i].cen);
      chk($sformatf("vec%0d_wen", i),      bus.MEM_WEN,  vecs[i].cen);
      chk($sformatf("vec%0d_a", i),        bus.MEM_A,    vecs[i].a);
      chk($sformatf("vec%0d_d", i),        bus.MEM_D,    vecs[i].md);
      chk($sformatf("vec%0d_core_rst", i), bus.CORE_RST, vecs[i].crst);
      chk($sformatf("vec%0d_done", i),     bus.DONE,     vecs[i].done);
      chk($sformatf("vec%0d_error", i),    bus.ERROR,    vecs[i].err);
    end
    @(negedge clk);
    bus.LOAD_REQ = 1'b0;
    bus.IN_VALID = 1'b0;

    // Same image, wrong checksum byte: both words still written, then ERR.
    wr_q.delete();
    exp_w[0] = 32'h00500013;
    exp_w[1] = 32'h00100093;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_payload(2, 1'b0, cs);
    send_byte(8'hD1, 1'b0);
    idle();
    check_writes("badcs_writes", 2);
    chk("badcs_error",    bus.ERROR,    1'b1);
    chk("badcs_core_rst", bus.CORE_RST, 1'b1);
    chk("badcs_done",     bus.DONE,     1'b0);
    chk("badcs_ready",    bus.IN_READY, 1'b0);
    pulse_load();
    chk("badcs_reload_error", bus.ERROR,    1'b0);
    chk("badcs_reload_ready", bus.IN_READY, 1'b1);

    // Zero length and over-length (2049) both fail without writing.
    wr_q.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle();
    chk("len0_error",  bus.ERROR,    1'b1);
    chk("len0_ready",  bus.IN_READY, 1'b0);
    chk("len0_writes", wr_q.size(),  0);
    pulse_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h08, 1'b0);
    idle();
    chk("len2049_error",    bus.ERROR,    1'b1);
    chk("len2049_core_rst", bus.CORE_RST, 1'b1);
    chk("len2049_writes",   wr_q.size(),  0);
    pulse_load();
    chk("len2049_reload_error", bus.ERROR,    1'b0);
    chk("len2049_reload_ready", bus.IN_READY, 1'b1);

    // 8-word image with IN_VALID toggling randomly.
    wr_q.delete();
    for (int i = 0; i < 8; i++) exp_w[i] = $urandom;
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_payload(8, 1'b1, cs);
    send_byte(cs, 1'b1);
    idle();
    check_writes("toggle_writes", 8);
    chk("toggle_done",     bus.DONE,     1'b1);
    chk("toggle_core_rst", bus.CORE_RST, 1'b0);
    chk("toggle_error",    bus.ERROR,    1'b0);

    // Reset arrives on the edge that accepts the 4th byte of word 1: that write must be dropped.
    pulse_load();
    wr_q.delete();
    exp_w[0] = 32'hDEADBEEF;
    exp_w[1] = 32'h01234567;
    exp_w[2] = 32'h89ABCDEF;
    exp_w[3] = 32'hCAFEF00D;
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 7; k++) send_byte(exp_w[k/4][8*(k%4) +: 8], 1'b0);
    @(negedge clk);
    bus.IN_DATA  = exp_w[1][31:24];
    bus.IN_VALID = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_wen",      bus.MEM_WEN,  1'b1);
    chk("midrst_cen",      bus.MEM_CEN,  1'b1);
    chk("midrst_ready",    bus.IN_READY, 1'b0);
    chk("midrst_core_rst", bus.CORE_RST, 1'b1);
    chk("midrst_done",     bus.DONE,     1'b0);
    chk("midrst_a",        bus.MEM_A,    11'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    chk("midrst_write_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("midrst_write0", wr_q[0].d, exp_w[0]);
    chk("midrst_rel_ready", bus.IN_READY, 1'b0);
    wr_q.delete();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_payload(4, 1'b0, cs);
    send_byte(cs, 1'b0);
    idle();
    check_writes("midrst_reload", 4);
    chk("midrst_reload_done",     bus.DONE,     1'b1);
    chk("midrst_reload_core_rst", bus.CORE_RST, 1'b0);

    // Full-depth image: payload byte k = k[7:0]; XOR over 32 full 0..255 runs is 0.
    pulse_load();
    wr_q.delete();
    for (int i = 0; i < 2048; i++) begin
      exp_w[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b0);
    send_payload(2048, 1'b0, cs);
    chk("full_csum_model", cs, 8'h00);
    send_byte(8'h00, 1'b0);
    idle();
    check_writes("full_writes", 2048);
    if (wr_q.size() > 0) begin
      chk("full_last_a", wr_q[wr_q.size()-1].a, 11'h7FF);
      chk("full_last_d", wr_q[wr_q.size()-1].d, 32'hFFFEFDFC);
    end
    chk("full_done",     bus.DONE,     1'b1);
    chk("full_core_rst", bus.CORE_RST, 1'b0);
    chk("full_error",    bus.ERROR,    1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
